// File: rtl/conv3x3_edge_filter_pkg.sv
// Shared types and helpers for the 3x3 Sobel edge filter.
// Gradient/magnitude widths are expressed as paddings over the pixel width DW.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_GX   = 2'b01,
        MODE_GY   = 2'b10,
        MODE_SUM  = 2'b11
    } mode_e;

    // Signed gradient is DW+3 bits, |Gx|+|Gy| magnitude is DW+4 bits.
    localparam int unsigned GW_PAD = 3;
    localparam int unsigned MW_PAD = 4;

    // Right-shift a magnitude and clamp it to the largest DW-bit pixel value.
    function automatic logic [31:0] abs_sat(input logic [31:0] mag,
                                            input int unsigned shamt,
                                            input int unsigned dw);
        logic [31:0] shifted;
        logic [31:0] max_val;
        shifted = mag >> shamt;
        max_val = (32'd1 << dw) - 32'd1;
        return (shifted > max_val) ? max_val : shifted;
    endfunction

endpackage

// File: rtl/conv3x3_edge_filter_line_delay.sv
// Line delay of DEPTH accepted samples, built as a circular buffer so the
// storage can map onto RAM; only the pointer is reset.
module line_delay #(
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 640
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Read-before-write at the same slot yields the sample from DEPTH accepts ago.
    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/conv3x3_edge_filter.sv
// Streaming 3x3 Sobel edge filter: window build, gradient, magnitude/threshold.
// Fixed 3-cycle latency, gaps preserved, border pixels forced to zero.
module conv3x3_edge_filter
    import conv_pkg::*;
#(
    parameter int unsigned DW        = 12,
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned OUT_SHIFT = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic          iSOF,
    input  logic [1:0]    iMODE,
    input  logic          iTHR_EN,
    input  logic [DW-1:0] iTHRESH,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic          oSOF
);
    localparam int unsigned GW = DW + GW_PAD;
    localparam int unsigned MW = DW + MW_PAD;
    localparam int unsigned CW = $clog2(IMG_W);

    // Frame tracking and configuration shadows
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic          synced_q, synced_d;
    mode_e         mode_q, mode_d;
    logic          thr_en_q, thr_en_d;
    logic [DW-1:0] thresh_q, thresh_d;

    logic          accept;
    logic [CW-1:0] pix_col;
    logic [1:0]    pix_row;
    logic          border;
    mode_e         eff_mode;
    logic          eff_thr_en;
    logic [DW-1:0] eff_thresh;

    // An accepted SOF applies to its own pixel, so decode it combinationally.
    assign accept     = iDVAL & (synced_q | iSOF);
    assign pix_col    = iSOF ? '0 : col_q;
    assign pix_row    = iSOF ? '0 : row_q;
    assign border     = (pix_row < 2'd2) || (pix_col < CW'(2));
    assign eff_mode   = iSOF ? mode_e'(iMODE) : mode_q;
    assign eff_thr_en = iSOF ? iTHR_EN : thr_en_q;
    assign eff_thresh = iSOF ? iTHRESH : thresh_q;

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        synced_d = synced_q;
        mode_d   = mode_q;
        thr_en_d = thr_en_q;
        thresh_d = thresh_q;
        if (accept) begin
            mode_d   = eff_mode;
            thr_en_d = eff_thr_en;
            thresh_d = eff_thresh;
            synced_d = 1'b1;
            if (pix_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (pix_row == 2'd2) ? 2'd2 : pix_row + 2'd1;
            end else begin
                col_d = pix_col + CW'(1);
                row_d = pix_row;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q    <= '0;
            row_q    <= '0;
            synced_q <= 1'b0;
            mode_q   <= MODE_SUM;
            thr_en_q <= 1'b0;
            thresh_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            synced_q <= synced_d;
            mode_q   <= mode_d;
            thr_en_q <= thr_en_d;
            thresh_q <= thresh_d;
        end
    end

    logic [DW-1:0] line1_out;
    logic [DW-1:0] line2_out;

    line_delay #(.DW(DW), .DEPTH(IMG_W)) u_line1 (
        .clk_i  (iCLK),
        .rst_ni (iRST),
        .en_i   (accept),
        .din_i  (iDATA),
        .dout_o (line1_out)
    );

    line_delay #(.DW(DW), .DEPTH(IMG_W)) u_line2 (
        .clk_i  (iCLK),
        .rst_ni (iRST),
        .en_i   (accept),
        .din_i  (line1_out),
        .dout_o (line2_out)
    );

    // Stage 1: 3x3 window, win_q[row][col] with row 0 oldest line, col 2 newest
    logic [DW-1:0] win_q [3][3];
    logic          v1_q, sof1_q, border1_q, thr1_q;
    mode_e         mode1_q;
    logic [DW-1:0] thresh1_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            v1_q      <= 1'b0;
            sof1_q    <= 1'b0;
            border1_q <= 1'b1;
            thr1_q    <= 1'b0;
            mode1_q   <= MODE_SUM;
            thresh1_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= line2_out;
                win_q[1][2] <= line1_out;
                win_q[2][2] <= iDATA;
                sof1_q      <= iSOF;
                border1_q   <= border;
                thr1_q      <= eff_thr_en;
                mode1_q     <= eff_mode;
                thresh1_q   <= eff_thresh;
            end
        end
    end

    // Stage 2: Sobel gradients
    logic signed [GW-1:0] s [3][3];
    logic signed [GW-1:0] gx_d, gy_d;

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                s[r][c] = $signed(GW'(win_q[r][c]));
            end
        end
        gx_d = (s[0][2] + (s[1][2] <<< 1) + s[2][2]) - (s[0][0] + (s[1][0] <<< 1) + s[2][0]);
        gy_d = (s[2][0] + (s[2][1] <<< 1) + s[2][2]) - (s[0][0] + (s[0][1] <<< 1) + s[0][2]);
    end

    logic signed [GW-1:0] gx_q, gy_q;
    logic [DW-1:0]        center_q;
    logic                 v2_q, sof2_q, border2_q, thr2_q;
    mode_e                mode2_q;
    logic [DW-1:0]        thresh2_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            gx_q      <= '0;
            gy_q      <= '0;
            center_q  <= '0;
            v2_q      <= 1'b0;
            sof2_q    <= 1'b0;
            border2_q <= 1'b1;
            thr2_q    <= 1'b0;
            mode2_q   <= MODE_SUM;
            thresh2_q <= '0;
        end else begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            center_q  <= win_q[1][1];
            v2_q      <= v1_q;
            sof2_q    <= sof1_q;
            border2_q <= border1_q;
            thr2_q    <= thr1_q;
            mode2_q   <= mode1_q;
            thresh2_q <= thresh1_q;
        end
    end

    // Stage 3: magnitude, scaling, threshold, border mask
    logic signed [GW-1:0] ngx, ngy;
    logic [MW-1:0]        agx, agy, mag;
    logic [DW-1:0]        scaled, res;

    always_comb begin
        ngx = -gx_q;
        ngy = -gy_q;
        agx = gx_q[GW-1] ? MW'($unsigned(ngx)) : MW'($unsigned(gx_q));
        agy = gy_q[GW-1] ? MW'($unsigned(ngy)) : MW'($unsigned(gy_q));
        unique case (mode2_q)
            MODE_GX:  mag = agx;
            MODE_GY:  mag = agy;
            MODE_SUM: mag = agx + agy;
            default:  mag = '0;
        endcase
        scaled = DW'(abs_sat(32'(mag), OUT_SHIFT, DW));
        res    = (mode2_q == MODE_PASS) ? center_q : scaled;
        if (thr2_q) begin
            res = (res >= thresh2_q) ? '1 : '0;
        end
        if (border2_q) begin
            res = '0;
        end
    end

    logic [DW-1:0] odata_q;
    logic          odval_q, osof_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            odata_q <= '0;
            odval_q <= 1'b0;
            osof_q  <= 1'b0;
        end else begin
            odata_q <= v2_q ? res : '0;
            odval_q <= v2_q;
            osof_q  <= v2_q & sof2_q;
        end
    end

    assign oDATA = odata_q;
    assign oDVAL = odval_q;
    assign oSOF  = osof_q;

endmodule

// File: doc/conv3x3_edge_filter.md
Name: conv3x3_edge_filter

Overview:
Parametrised 3x3 streaming edge filter for the camera pipeline, placed after the Bayer-to-grayscale stage and before the VGA/SDRAM writer.
- Builds a 3x3 window from a raster-order grayscale stream using two internal line delays.
- Computes Sobel Gx/Gy and outputs one of four runtime modes: passthrough, |Gx|, |Gy|, |Gx|+|Gy|.
- Scaling, saturation and optional binary thresholding are applied to the result.
- Improvements over the previous generation: explicit border masking, frame-synchronous mode switching, and valid tracking that handles gaps.

Parameters:
DW, 12, pixel width in bits for input and output.
IMG_W, 640, pixels per line; line-delay depth; must be at least 4.
OUT_SHIFT, 2, right shift applied to the magnitude before saturation.

Ports:
iCLK  in  1  clock.
iRST  in  1  asynchronous, active-low reset.
iDATA  in  DW  grayscale pixel.
iDVAL  in  1  pixel valid; gaps allowed.
iSOF  in  1  first pixel of frame; qualified by iDVAL.
iMODE  in  2  00 PASS, 01 GX, 10 GY, 11 SUM; sampled at SOF.
iTHR_EN  in  1  binarize enable; sampled at SOF.
iTHRESH  in  DW  threshold; sampled at SOF.
oDATA  out  DW  filtered pixel.
oDVAL  out  1  output valid.
oSOF  out  1  aligned with the first output pixel of a frame.

Behaviour:
- Reset (iRST low, async): all outputs 0; col/row counters 0; mode shadow = SUM; THR_EN shadow = 0; THRESH shadow = 0; synced flag = 0. Line-delay storage is not reset (RAM-inferable).
- Accept: pixel accepted when iDVAL=1. While synced=0, pixels without iSOF are dropped and produce no oDVAL.
- iSOF & iDVAL:
  - col=0, row=0, synced=1.
  - Latch iMODE/iTHR_EN/iTHRESH into shadows, effective for this pixel onward.
  - iSOF mid-line restarts the counters immediately.
- Counters: col 0..IMG_W-1, wraps to 0. Row increments on wrap and saturates at 2 (only row<2 is needed).
- Stage 1, on accept:
  - Both line delays shift.
  - Window columns shift left; newest column = {line2 out, line1 out, iDATA}.
  - Border flag = (row<2) | (col<2), using the pre-increment values of the incoming pixel.
  - Window centre = pixel (row-1, col-1).
- Stage 2: Gx = (a02+2a12+a22)-(a00+2a10+a20); Gy = (a20+2a21+a22)-(a00+2a01+a02). Signed, DW+3 bits, registered.
- Stage 3:
  - Magnitude m = |Gx| (GX), |Gy| (GY), or |Gx|+|Gy| (SUM; DW+4 bits).
  - r = m>>OUT_SHIFT, saturated to 2^DW-1. PASS: r = a11.
  - If THR_EN: r = (r>=THRESH) ? 2^DW-1 : 0.
  - If border: r = 0 (all modes, regardless of threshold).
- Latency: iDVAL accepted at edge t → oDVAL=1 for the cycle after edge t+2 (3 cycles). Gaps are preserved one-for-one; no back-pressure.
- Output coverage: every accepted pixel yields exactly one output. The last image row is never a window centre (frame output lags one line); the next frame's rows 0-1 emit border zeros.
- oSOF: iSOF delayed with the pipeline; high only with oDVAL.
- Mode/threshold inputs changed mid-frame have no effect until the next accepted iSOF.
- Reset mid-frame: pipeline valids cleared immediately; no output until the next iSOF.

Decomposition:
- Package conv_pkg: mode_e enum (PASS, GX, GY, SUM); localparams GW=DW+3 and MW=DW+4; function abs_sat.
- Sub-module line_delay #(DW, DEPTH):
  - Enable-gated shift register or inferred RAM with a fixed latency of DEPTH accepts.
  - Instantiated twice.

Test Plan:
Benches use IMG_W=8, DW=12, OUT_SHIFT=2.
1. Reset, SOF, constant frame of 100, mode SUM, 8x8 continuous → 64 oDVAL pulses, all oDATA=0; first oDVAL 3 cycles after the first iDVAL; oSOF on the first.
2. Cols 0-3=0, cols 4-7=1000, mode GX → rows≥1 (centre): centre cols 3 and 4 = 1000, others 0. Same stimulus, mode GY → all 0.
3. Rows 0-3=0, rows 4-7=4095, mode SUM → centre rows 3 and 4 = 4095 (16380>>2, saturated); border outputs (incoming row<2 or col<2) = 0.
4. Test 2 stimulus, THR_EN=1, THRESH=500 → edge centres 4095, others 0. Repeat with THRESH=1001 → all 0.
5. Change iMODE GX→PASS mid-frame 1 → frame 1 stays GX; frame 2 interior outputs equal a11 (delayed input pixels).
6. Random iDVAL gaps (50%) → output sequence matches the gap-free golden model. Pixels before the first SOF → no oDVAL. iRST pulse mid-line → oDVAL=0 the next cycle until SOF + 3.
